// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types, polarity constants and helpers for the seven-segment scan driver
package seven_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    localparam logic [6:0] SEG_OFF_HI = 7'h7F;
    localparam logic [6:0] SEG_OFF_LO = 7'h00;

    // PWM counter runs 0..PWM_LAST, so brightness 15 is always lit
    localparam logic [3:0] PWM_LAST = 4'd14;

    function automatic logic [6:0] seg_polarity(input logic [6:0] pattern, input logic active_low);
        return active_low ? ~pattern : pattern;
    endfunction

endpackage

// File: rtl/seven_seg_pwm.sv
// rtl/seven_seg_pwm.sv - period-15 brightness counter producing the digit lit gate
module seven_seg_pwm
    import seven_seg_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [3:0] brightness,
    output logic       lit
);

    logic [3:0] pwm_cnt;

    // Held at zero outside DRIVE so every drive window starts on a lit phase
    always_ff @(posedge clk) begin
        if (!reset_n || !run) begin
            pwm_cnt <= 4'd0;
        end else if (pwm_cnt == PWM_LAST) begin
            pwm_cnt <= 4'd0;
        end else begin
            pwm_cnt <= pwm_cnt + 4'd1;
        end
    end

    assign lit = (pwm_cnt < brightness);

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed seven-segment driver with blanking, PWM and frame latching
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 8,
    parameter int CLK_DIV        = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic [NUM_DIGITS*7-1:0] digit_pattern,
    input  logic [3:0]              brightness,
    output logic [6:0]              seg_o,
    output logic [NUM_DIGITS-1:0]   dig_en_o,
    output logic                    frame_tick
);

    localparam int SLOT_W = $clog2(CLK_DIV);
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [SLOT_W-1:0]     SLOT_LAST  = SLOT_W'(CLK_DIV - 1);
    localparam logic [SLOT_W-1:0]     BLANK_LAST = SLOT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = SEG_ACTIVE_LOW ? SEG_OFF_HI : SEG_OFF_LO;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF    = DIG_ACTIVE_LOW ? '1 : '0;

    scan_state_t             state;
    logic [SLOT_W-1:0]       slot_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [NUM_DIGITS*7-1:0] shadow;
    logic [6:0]              cur_pat;
    logic [NUM_DIGITS-1:0]   dig_onehot;
    logic [NUM_DIGITS-1:0]   dig_sel;
    logic                    pwm_lit;

    seven_seg_pwm u_pwm (
        .clk        (clk),
        .reset_n    (reset_n),
        .run        (state == ST_DRIVE),
        .brightness (brightness),
        .lit        (pwm_lit)
    );

    assign cur_pat    = shadow[digit_idx*7 +: 7];
    assign dig_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
    assign dig_sel    = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;

    // Pins default to off every cycle; only a lit DRIVE cycle overrides them,
    // so segments and enables always move together.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            slot_cnt   <= '0;
            digit_idx  <= '0;
            shadow     <= '0;
            seg_o      <= SEG_OFF;
            dig_en_o   <= DIG_OFF;
            frame_tick <= 1'b0;
        end else begin
            seg_o      <= SEG_OFF;
            dig_en_o   <= DIG_OFF;
            frame_tick <= 1'b0;
            if (!enable) begin
                state     <= ST_IDLE;
                slot_cnt  <= '0;
                digit_idx <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        state      <= ST_BLANK;
                        slot_cnt   <= '0;
                        digit_idx  <= '0;
                        shadow     <= digit_pattern;
                        frame_tick <= 1'b1;
                    end
                    ST_BLANK: begin
                        slot_cnt <= slot_cnt + 1'b1;
                        if (slot_cnt == BLANK_LAST) begin
                            state <= ST_DRIVE;
                        end
                    end
                    ST_DRIVE: begin
                        if (pwm_lit) begin
                            seg_o    <= seg_polarity(cur_pat, SEG_ACTIVE_LOW);
                            dig_en_o <= dig_sel;
                        end
                        if (slot_cnt == SLOT_LAST) begin
                            slot_cnt <= '0;
                            state    <= ST_BLANK;
                            if (digit_idx == IDX_LAST) begin
                                digit_idx  <= '0;
                                shadow     <= digit_pattern;
                                frame_tick <= 1'b1;
                            end else begin
                                digit_idx <= digit_idx + 1'b1;
                            end
                        end else begin
                            slot_cnt <= slot_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - scoreboard bench for the seven-segment scan driver
module tb_seven_seg_scan_driver;

    localparam logic [27:0] PAT_A = {7'h66, 7'h4F, 7'h5B, 7'h06};
    localparam logic [27:0] PAT_B = {7'h66, 7'h7F, 7'h5B, 7'h06};

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [27:0] digit_pattern;
    logic [3:0]  brightness;
    logic [6:0]  seg_o;
    logic [3:0]  dig_en_o;
    logic        frame_tick;

    always #5 clk = ~clk;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (4),
        .CLK_DIV        (20),
        .BLANK_CYCLES   (4),
        .SEG_ACTIVE_LOW (1'b1),
        .DIG_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .enable        (enable),
        .digit_pattern (digit_pattern),
        .brightness    (brightness),
        .seg_o         (seg_o),
        .dig_en_o      (dig_en_o),
        .frame_tick    (frame_tick)
    );

    typedef struct {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       ft;
        string      name;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_off(input int n, input logic ft, input string name);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.seg = 7'h7F; e.dig = 4'hF; e.ft = ft; e.name = name;
            exp_q.push_back(e);
        end
    endtask

    // Output c (1-based, c=0 is the frame_tick cycle) of a scan started by enable:
    // slot = (c-1)%20, digit = ((c-1)/20)%4, lit in slot 4..19 when (slot-4)%15 < brightness.
    task automatic push_scan(input logic [27:0] pa, input logic [27:0] pb, input int n,
                             input int br, input string name);
        exp_t        e;
        logic [27:0] p;
        int          k, s;
        for (int c = 1; c <= n; c++) begin
            k = ((c - 1) / 20) % 4;
            s = (c - 1) % 20;
            p = (((c - 1) / 80) == 0) ? pa : pb;
            e.name = name;
            e.ft   = ((c % 80) == 0);
            if (s >= 4 && ((s - 4) % 15) < br) begin
                e.seg = ~p[k*7 +: 7];
                e.dig = ~(4'b0001 << k);
            end else begin
                e.seg = 7'h7F;
                e.dig = 4'hF;
            end
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            checks++;
            if (seg_o !== mon_e.seg || dig_en_o !== mon_e.dig || frame_tick !== mon_e.ft) begin
                errors++;
                $display("FAIL %s t=%0t: got seg=%h dig=%h ft=%b, expected seg=%h dig=%h ft=%b",
                         mon_e.name, $time, seg_o, dig_en_o, frame_tick, mon_e.seg, mon_e.dig, mon_e.ft);
            end
        end
    end

    logic [6:0] prev_seg;
    logic [3:0] prev_dig;
    logic       inv_armed = 1'b0;

    always @(negedge clk) begin
        checks++;
        assert ($countones(~dig_en_o) <= 1)
        else begin
            errors++;
            $display("FAIL onehot t=%0t: dig=%h, expected at most one active digit", $time, dig_en_o);
        end
        if (inv_armed && prev_dig != 4'hF && dig_en_o != 4'hF) begin
            checks++;
            assert (seg_o === prev_seg && dig_en_o === prev_dig)
            else begin
                errors++;
                $display("FAIL ghost t=%0t: seg=%h dig=%h, expected unchanged seg=%h dig=%h",
                         $time, seg_o, dig_en_o, prev_seg, prev_dig);
            end
        end
        prev_seg  <= seg_o;
        prev_dig  <= dig_en_o;
        inv_armed <= 1'b1;
    end

    initial begin
        reset_n       = 1'b0;
        enable        = 1'b0;
        brightness    = 4'd15;
        digit_pattern = PAT_A;

        push_off(3, 1'b0, "reset");
        repeat (3) tick();

        // Scan two frames and into digit 1 of the third; digit 2 changes mid-frame
        reset_n = 1'b1;
        enable  = 1'b1;
        push_off(1, 1'b1, "start_tick");
        push_scan(PAT_A, PAT_B, 190, 15, "scan_full");
        repeat (30) tick();
        digit_pattern = PAT_B;
        repeat (161) tick();

        enable = 1'b0;
        push_off(3, 1'b0, "disable");
        repeat (3) tick();

        brightness = 4'd4;
        enable     = 1'b1;
        push_off(1, 1'b1, "pwm4_tick");
        push_scan(PAT_B, PAT_B, 80, 4, "pwm4");
        repeat (81) tick();

        enable = 1'b0;
        push_off(2, 1'b0, "disable2");
        repeat (2) tick();
        brightness = 4'd0;
        enable     = 1'b1;
        push_off(1, 1'b1, "dark_tick");
        push_scan(PAT_B, PAT_B, 80, 0, "dark");
        repeat (81) tick();

        enable = 1'b0;
        push_off(2, 1'b0, "disable3");
        repeat (2) tick();
        brightness = 4'd15;
        enable     = 1'b1;
        push_off(1, 1'b1, "pre_reset_tick");
        push_scan(PAT_B, PAT_B, 30, 15, "pre_reset");
        repeat (31) tick();

        reset_n = 1'b0;
        #2;
        checks++;
        if (seg_o !== 7'h24 || dig_en_o !== 4'hD) begin
            errors++;
            $display("FAIL reset_async: seg=%h dig=%h between edges, expected seg=24 dig=d", seg_o, dig_en_o);
        end
        push_off(1, 1'b0, "sync_reset");
        tick();
        reset_n = 1'b1;
        push_off(1, 1'b1, "post_reset_tick");
        push_scan(PAT_B, PAT_B, 40, 15, "post_reset");
        repeat (41) tick();

        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 199) == 0) enable = ~enable;
            if ($urandom_range(0, 99) == 0) brightness = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) digit_pattern = 28'($urandom);
            reset_n = ($urandom_range(0, 999) != 0);
            tick();
        end
        reset_n = 1'b1;

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
